uart_rx: RTL and testbench

Serial UART receiver that consumes the 16x-oversample `rxClk` produced by the baud-rate generator and converts the `rx` line into parallel bytes. It sits directly downstream of the baud-rate generator and upstream of the security-system command logic, on the board clock `clk`. Each received byte is presented on a valid/ack handshake. Framing and overrun errors are reported.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: FSM state codes and oversampling defaults.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST_TICK  = OVERSAMPLE - 1;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_START = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
  localparam logic [STATE_W-1:0] ST_STOP  = 3'd3;
  localparam logic [STATE_W-1:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus rising-edge detector on the
// oversample strobe; tick_c_o is one clk wide per rxClk period.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  input  logic rx_clk_i,
  output logic rx_s_o,
  output logic tick_c_o
);

  logic rx_meta_q;
  logic rx_s_q;
  logic rx_clk_q;

  // Line resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_clk_q  <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_clk_q  <= rx_clk_i;
    end
  end

  assign rx_s_o   = rx_s_q;
  assign tick_c_o = rx_clk_i & ~rx_clk_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversample strobe; presents bytes on a
// valid/ack handshake and flags framing and overrun errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxClk,
  input  logic                 rx,
  input  logic                 rxAck,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid,
  output logic                 rxFrameErr,
  output logic                 rxOverrun
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned MID    = OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST   = OVERSAMPLE - 1;

  logic rx_s;
  logic tick_c;

  logic [STATE_W-1:0]   state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_i     (rx),
    .rx_clk_i (rxClk),
    .rx_s_o   (rx_s),
    .tick_c_o (tick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // Ack is applied first so a load on the same cycle overrides it.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = ovr_q;

    if (rxAck && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (tick_c) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end
        ST_START: begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(MID)) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = ST_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(LAST)) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              state_d = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(LAST)) begin
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              if (valid_q && !rxAck) begin
                ovr_d = 1'b1;
              end
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end
        end
        // Wait for the line to return high so a held break is not re-read as data.
        ST_BREAK: begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rxData     = data_q;
  assign rxValid    = valid_q;
  assign rxFrameErr = ferr_q;
  assign rxOverrun  = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// compared against a byte-level handshake model.
module tb_uart_rx;

  localparam int BIT_CLK    = 448;
  localparam int RXCLK_PER  = 28;
  localparam int LOAD_NEG   = 4284;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rxAck = 1'b0;
  logic       rx_clk;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxFrameErr;
  logic       rxOverrun;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;
  int ferr_exp = 0;

  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ovr = 1'b0;

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxClk      (rx_clk),
    .rx         (rx),
    .rxAck      (rxAck),
    .rxData     (rxData),
    .rxValid    (rxValid),
    .rxFrameErr (rxFrameErr),
    .rxOverrun  (rxOverrun)
  );

  always #5 clk = ~clk;

  // Baud generator stand-in: 28-clk period oversample strobe.
  always @(posedge clk) cyc <= cyc + 1;
  assign rx_clk = (cyc % RXCLK_PER) < (RXCLK_PER / 2);

  always @(negedge clk) begin
    if (rst_n && rxFrameErr) ferr_seen <= ferr_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "/data"},  32'(rxData),    32'(exp_data));
    check_eq({tag, "/valid"}, 32'(rxValid),   32'(exp_valid));
    check_eq({tag, "/ovr"},   32'(rxOverrun), 32'(exp_ovr));
    check_eq({tag, "/ferr"},  32'(ferr_seen), 32'(ferr_exp));
  endtask

  task automatic model_load(input logic [7:0] b);
    if (exp_valid) exp_ovr = 1'b1;
    exp_data  = b;
    exp_valid = 1'b1;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    do @(negedge clk); while ((cyc % RXCLK_PER) != 0);
  endtask

  // ack_at: negedge index within the frame at which rxAck is raised for one clk (-1: never).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at);
    int k;
    k = 0;
    align();
    for (int i = 0; i < 10; i++) begin
      rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      for (int j = 0; j < BIT_CLK; j++) begin
        @(negedge clk);
        k++;
        rxAck = (k == ack_at);
      end
    end
    rxAck = 1'b0;
  endtask

  task automatic pulse_ack(input string tag);
    @(negedge clk);
    rxAck = 1'b1;
    @(negedge clk);
    rxAck = 1'b0;
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end
    check_state(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       stop;

    wait_neg(3);
    check_state("reset");
    rst_n = 1'b1;
    wait_neg(50);

    send_frame(8'hA5, 1'b1, -1);
    model_load(8'hA5);
    check_state("good");
    pulse_ack("good_ack");

    align();
    rx = 1'b0;
    wait_neg(96);
    rx = 1'b1;
    wait_neg(400);
    check_state("false_start");

    send_frame(8'h3C, 1'b0, -1);
    ferr_exp++;
    wait_neg(3000);
    check_state("break");
    rx = 1'b1;
    wait_neg(100);
    send_frame(8'h11, 1'b1, -1);
    model_load(8'h11);
    check_state("after_break");
    pulse_ack("after_break_ack");

    send_frame(8'h01, 1'b1, -1);
    model_load(8'h01);
    send_frame(8'h02, 1'b1, -1);
    model_load(8'h02);
    check_state("overrun");
    pulse_ack("overrun_ack");

    b = 8'($urandom);
    send_frame(b, 1'b1, -1);
    model_load(b);
    check_state("collide_first");
    send_frame(8'h55, 1'b1, LOAD_NEG);
    exp_data  = 8'h55;
    exp_valid = 1'b1;
    exp_ovr   = 1'b0;
    check_state("collide");

    align();
    rx = 1'b0;
    wait_neg(BIT_CLK);
    rx = 1'b1;
    wait_neg(4 * BIT_CLK + 200);
    rst_n = 1'b0;
    #1;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    check_eq("rst_mid/data",  32'(rxData),     32'h0);
    check_eq("rst_mid/valid", 32'(rxValid),    32'h0);
    check_eq("rst_mid/ovr",   32'(rxOverrun),  32'h0);
    check_eq("rst_mid/ferr",  32'(rxFrameErr), 32'h0);
    wait_neg(5);
    rst_n = 1'b1;
    wait_neg(20);
    send_frame(8'h81, 1'b1, -1);
    model_load(8'h81);
    check_state("after_rst");

    for (int n = 0; n < 6; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, -1);
      rx = 1'b1;
      if (stop) model_load(b);
      else ferr_exp++;
      wait_neg(60);
      check_state("rand");
      if ($urandom_range(0, 1) == 1) pulse_ack("rand_ack");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
